// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_MEM_WAIT     = 2'd1,
    ST_INT_DRAIN    = 2'd2,
    ST_INT_REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_INT = 2'd2;
  localparam logic [1:0] PCSEL_EPC = 2'd3;

  localparam logic [31:0] INT_VECTOR_DEFAULT   = 32'h0000_0100;
  localparam int          DRAIN_CYCLES_DEFAULT = 2;
  localparam int          MEM_TIMEOUT_DEFAULT  = 255;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  output logic       load_use
);

  logic match_rs1;
  logic match_rs2;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign match_rs1 = id_uses_rs1 && (id_rs1 == ex_rd);
  assign match_rs2 = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use  = ex_load && (ex_rd != 5'd0) && (match_rs1 || match_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, memory wait and
// interrupt entry/return, with a drain phase before the interrupt redirect.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR   = INT_VECTOR_DEFAULT,
  parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int          MEM_TIMEOUT  = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        branch_taken,
  input  logic        ex_mret,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        int_req,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        memwb_flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] int_vec,
  output logic [31:0] epc,
  output logic        int_ack,
  output logic        mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t          state_reg;
  state_t          ret_reg;
  state_t          eff_state;
  logic [31:0]     epc_reg;
  logic            int_en_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic [DW-1:0]   drain_cnt_reg;
  logic            mem_err_reg;

  logic            load_use;
  logic            mem_wait_now;
  logic            wait_cycle;
  logic            accept;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_load     (ex_load),
    .load_use    (load_use)
  );

  // MEM_WAIT behaves as the state it interrupted once memory is ready, so the
  // ready cycle is a normal RUN or drain cycle.
  assign eff_state    = (state_reg == ST_MEM_WAIT) ? ret_reg : state_reg;
  assign mem_wait_now = mem_req && !mem_ready;
  assign wait_cycle   = mem_wait_now && (eff_state != ST_INT_REDIRECT);
  assign accept       = (eff_state == ST_RUN) && int_req && int_en_reg && id_valid &&
                        !branch_taken && !ex_mret && !load_use && !mem_wait_now;

  assign int_vec = INT_VECTOR;
  assign epc     = epc_reg;
  assign mem_err = mem_err_reg;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    pc_sel      = PCSEL_SEQ;
    int_ack     = 1'b0;
    if (!rst) begin
      if (wait_cycle) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end else begin
        case (eff_state)
          ST_RUN: begin
            if (branch_taken) begin
              pc_sel     = PCSEL_BR;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (ex_mret) begin
              pc_sel     = PCSEL_EPC;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (load_use) begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              idex_flush = 1'b1;
            end else if (accept) begin
              pc_stall   = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end
          end
          ST_INT_DRAIN: begin
            pc_stall   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end
          ST_INT_REDIRECT: begin
            pc_sel     = PCSEL_INT;
            int_ack    = 1'b1;
            ifid_flush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      ret_reg       <= ST_RUN;
      epc_reg       <= 32'd0;
      int_en_reg    <= 1'b1;
      wait_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      mem_err_reg   <= 1'b0;
    end else begin
      if (wait_cycle) begin
        if (wait_cnt_reg != CW'(MEM_TIMEOUT))
          wait_cnt_reg <= wait_cnt_reg + CW'(1);
        if (wait_cnt_reg >= CW'(MEM_TIMEOUT - 1))
          mem_err_reg <= 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end

      if (wait_cycle) begin
        state_reg <= ST_MEM_WAIT;
        ret_reg   <= eff_state;
      end else begin
        case (eff_state)
          ST_RUN: begin
            state_reg <= ST_RUN;
            if (!branch_taken && ex_mret) begin
              int_en_reg <= 1'b1;
            end else if (accept) begin
              epc_reg       <= id_pc;
              int_en_reg    <= 1'b0;
              drain_cnt_reg <= DW'(DRAIN_CYCLES);
              state_reg     <= ST_INT_DRAIN;
            end
          end
          ST_INT_DRAIN: begin
            drain_cnt_reg <= drain_cnt_reg - DW'(1);
            state_reg     <= (drain_cnt_reg == DW'(1)) ? ST_INT_REDIRECT : ST_INT_DRAIN;
          end
          default: state_reg <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: each directed vector queues its expected outputs; a negedge
// monitor pops and compares against the DUT.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_valid;
  logic [31:0] id_pc;
  logic        ex_load, branch_taken, ex_mret, mem_req, mem_ready, int_req;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, memwb_flush, int_ack, mem_err;
  logic [1:0]  pc_sel;
  logic [31:0] int_vec, epc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .INT_VECTOR   (32'h0000_0100),
    .DRAIN_CYCLES (2),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_valid(id_valid), .id_pc(id_pc), .ex_rd(ex_rd), .ex_load(ex_load),
    .branch_taken(branch_taken), .ex_mret(ex_mret), .mem_req(mem_req), .mem_ready(mem_ready),
    .int_req(int_req), .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .pc_sel(pc_sel), .int_vec(int_vec), .epc(epc),
    .int_ack(int_ack), .mem_err(mem_err)
  );

  // ctrl bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush
  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] LU   = 7'b110_0100;
  localparam logic [6:0] FL   = 7'b001_0100;
  localparam logic [6:0] WT   = 7'b110_1011;
  localparam logic [6:0] DR   = 7'b101_0100;
  localparam logic [6:0] RD   = 7'b001_0000;

  typedef struct {
    string       name;
    logic [6:0]  ctrl;
    logic [1:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  exp_t mon_t;
  int   tests    = 0;
  int   failures = 0;
  logic [6:0] act_ctrl;

  task automatic chk(input string name, input logic [6:0] ctrl, input logic [1:0] sel,
                     input logic ack, input logic err, input logic [31:0] e_epc);
    exp_t t;
    t.name = name; t.ctrl = ctrl; t.sel = sel; t.ack = ack; t.err = err; t.epc = e_epc;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_valid = 0;
    id_pc = 0; ex_load = 0; branch_taken = 0; ex_mret = 0; mem_req = 0; mem_ready = 0;
    int_req = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_t = q.pop_front();
        act_ctrl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush};
        tests++;
        if (act_ctrl !== mon_t.ctrl || pc_sel !== mon_t.sel || int_ack !== mon_t.ack ||
            mem_err !== mon_t.err || epc !== mon_t.epc || int_vec !== 32'h0000_0100) begin
          failures++;
          $display("FAIL %s: got ctrl=%b sel=%0d ack=%b err=%b epc=%h vec=%h; want ctrl=%b sel=%0d ack=%b err=%b epc=%h vec=00000100",
                   mon_t.name, act_ctrl, pc_sel, int_ack, mem_err, epc, int_vec,
                   mon_t.ctrl, mon_t.sel, mon_t.ack, mon_t.err, mon_t.epc);
        end else begin
          $display("[TB] %s ok ctrl=%b sel=%0d epc=%h", mon_t.name, act_ctrl, pc_sel, epc);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    branch_taken = 1;
    chk("reset_outputs_zero", NONE, 0, 0, 0, 32'h0);
    rst = 1'b0; branch_taken = 0;

    ex_load = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    chk("loaduse_rs2", LU, 0, 0, 0, 32'h0);
    ex_load = 0;
    chk("loaduse_clear", NONE, 0, 0, 0, 32'h0);
    ex_load = 1; ex_rd = 0; id_rs2 = 0;
    chk("loaduse_x0", NONE, 0, 0, 0, 32'h0);
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1; id_uses_rs2 = 0;
    chk("loaduse_rs1", LU, 0, 0, 0, 32'h0);
    id_uses_rs1 = 0;
    chk("loaduse_unused_src", NONE, 0, 0, 0, 32'h0);
    id_uses_rs1 = 1; branch_taken = 1;
    chk("branch_over_loaduse", FL, 1, 0, 0, 32'h0);

    idle(); mem_req = 1;
    for (int i = 0; i < 3; i++) chk("mem_wait", WT, 0, 0, 0, 32'h0);
    mem_ready = 1;
    chk("mem_ready_unstalled", NONE, 0, 0, 0, 32'h0);

    idle(); int_req = 1; id_valid = 1; id_pc = 32'h40;
    chk("int_accept", DR, 0, 0, 0, 32'h0);
    chk("int_drain_1", DR, 0, 0, 0, 32'h40);
    chk("int_drain_2", DR, 0, 0, 0, 32'h40);
    chk("int_redirect", RD, 2, 1, 0, 32'h40);
    chk("int_nested_ignored_a", NONE, 0, 0, 0, 32'h40);
    chk("int_nested_ignored_b", NONE, 0, 0, 0, 32'h40);
    ex_mret = 1;
    chk("mret_return", FL, 3, 0, 0, 32'h40);
    ex_mret = 0; id_pc = 32'h80;
    chk("int_accept_2", DR, 0, 0, 0, 32'h40);
    chk("int_drain_2_1", DR, 0, 0, 0, 32'h80);
    mem_req = 1;
    chk("drain_mem_wait_a", WT, 0, 0, 0, 32'h80);
    chk("drain_mem_wait_b", WT, 0, 0, 0, 32'h80);
    mem_ready = 1;
    chk("drain_mem_ready", DR, 0, 0, 0, 32'h80);
    mem_ready = 0;
    chk("redirect_ignores_wait", RD, 2, 1, 0, 32'h80);
    idle(); ex_mret = 1;
    chk("mret_return_2", FL, 3, 0, 0, 32'h80);

    idle(); int_req = 1; id_valid = 1; id_pc = 32'hC0;
    chk("int_accept_3", DR, 0, 0, 0, 32'h80);
    chk("int_drain_3_1", DR, 0, 0, 0, 32'hC0);
    rst = 1;
    chk("rst_mid_drain", NONE, 0, 0, 0, 32'hC0);
    rst = 0; int_req = 0;
    chk("after_rst_run", NONE, 0, 0, 0, 32'h0);

    int_req = 1; id_valid = 0; id_pc = 32'h10;
    chk("int_deferred_no_valid", NONE, 0, 0, 0, 32'h0);
    id_valid = 1; branch_taken = 1;
    chk("int_deferred_branch", FL, 1, 0, 0, 32'h0);
    branch_taken = 0; ex_load = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    chk("int_deferred_loaduse", LU, 0, 0, 0, 32'h0);

    idle(); mem_req = 1;
    for (int i = 0; i < 4; i++) chk("timeout_wait", WT, 0, 0, 0, 32'h0);
    chk("timeout_flag_set", WT, 0, 0, 1, 32'h0);
    mem_ready = 1;
    chk("timeout_sticky_ready", NONE, 0, 0, 1, 32'h0);
    idle();
    chk("timeout_sticky_idle", NONE, 0, 0, 1, 32'h0);
    rst = 1;
    chk("timeout_during_rst", NONE, 0, 0, 1, 32'h0);
    rst = 0;
    chk("timeout_cleared", NONE, 0, 0, 0, 32'h0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
